// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add MULT/MULTU, restoring DIV/DIVU.
// Optional macro MD_FAST_MUL_EN replaces the iterative multiplier with a single-cycle one.
module md_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic            mult,
    input  logic            div,
    input  logic            mdsign,
    input  logic [1:0]      hilowen,
    input  logic [1:0]      hiloren,
    input  logic [XLEN-1:0] rega,
    input  logic [XLEN-1:0] regb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

`ifdef MD_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;
`endif

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;       // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
    logic              sign_q, sign_r, is_div, div_zero;
    logic              accept, hilo_wr, last;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN+1:0]   div_trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    assign a_mag  = (mdsign && rega[XLEN-1]) ? -rega : rega;
    assign b_mag  = (mdsign && regb[XLEN-1]) ? -regb : regb;
    assign accept  = (state == IDLE) && start && !flush && (mult || div);
    assign hilo_wr = (state == IDLE) && start && !flush && !mult && !div && (hilowen != 2'b00);
    assign last    = (cnt == CNT_W'(XLEN - 1));

    // Trial subtract of the shifted partial remainder; top bit set means it went negative.
    assign div_trial = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, opnd};

    assign prod_fix = sign_q ? -acc : acc;
    assign quot_fix = sign_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = sign_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

`ifndef MD_FAST_MUL_EN
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE) || (start && (mult || div) && !flush);
        done       = (state == FIX) && !flush;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef MD_FAST_MUL_EN
                        next_state = div ? DIV : FIX;
`else
                        next_state = div ? DIV : MUL;
`endif
                    end
                end
`ifndef MD_FAST_MUL_EN
                MUL:     if (last) next_state = FIX;
`endif
                DIV:     if (last) next_state = FIX;
                FIX:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                sign_q   <= mdsign & (rega[XLEN-1] ^ regb[XLEN-1]);
                sign_r   <= mdsign & rega[XLEN-1];
                is_div   <= div;
                div_zero <= (regb == '0);
                if (div) begin
                    acc  <= {{XLEN{1'b0}}, a_mag};
                    opnd <= b_mag;
                end else begin
`ifdef MD_FAST_MUL_EN
                    acc  <= {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
                    acc  <= {{XLEN{1'b0}}, b_mag};
`endif
                    opnd <= a_mag;
                end
            end
            case (state)
`ifndef MD_FAST_MUL_EN
                MUL: begin
                    acc <= {mul_sum, acc[XLEN-1:1]};
                    cnt <= cnt + 1'b1;
                end
`endif
                DIV: begin
                    if (!div_trial[XLEN+1])
                        acc <= {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                    else
                        acc <= {acc[2*XLEN-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
            // Divide by zero leaves the dividend as remainder, so only the quotient needs forcing.
            if (state == FIX && !flush) begin
                if (is_div) begin
                    lo <= div_zero ? {XLEN{1'b1}} : quot_fix;
                    hi <= rem_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end else if (hilo_wr) begin
                if (hilowen[1]) hi <= rega;
                if (hilowen[0]) lo <= rega;
            end
        end
    end

    always_comb begin
        case (hiloren)
            2'b10, 2'b11: rdata = hi;
            default:      rdata = lo;
        endcase
    end

endmodule
